r3_mul_ctrl: RTL
================

// Module: r3_mul_ctrl
// PURPOSE
//  Host-side driver for the R3 multiplier (R3[x]/(x^761-x-1), 64-bit packed words, 32 coefs/word).
//  Accepts two 761-coef operand streams, packs them and writes multiplier BRAMs 0/1 (words 0..23).
//  Pulses start, waits for done, reads 24 result words through the multiplier read port,
//  unpacks them to a 761-coef output stream, then clears the multiplier.
// PARAMETERS
//  P        761  polynomial length (coefs per operand/result)
//  NW       24   packed words per polynomial, ceil(P/32)
//  RD_LAT   1    cycles from mul_do_addr change to valid mul_do
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-high
//  s_valid        in   1   input coef pair valid
//  s_ready        out  1   input accepted when s_valid&s_ready
//  s_coef_f       in   2   operand F coef k, F3 code {c1,c0}: 00=0, 01=+1, 10=-1
//  s_coef_g       in   2   operand G coef k, same code
//  mul_wr_en_0    out  1   multiplier F BRAM write enable
//  mul_wr_addr_0  out  5   F word address 0..23
//  mul_wr_din_0   out  64  F packed word, coef j in bits [2j+1:2j]
//  mul_wr_en_1    out  1   multiplier G BRAM write enable
//  mul_wr_addr_1  out  5   G word address
//  mul_wr_din_1   out  64  G packed word
//  mul_in_ready   out  1   start pulse to multiplier
//  mul_valid      in   1   multiplier done (level, held until cleared)
//  mul_rst        out  1   multiplier reset
//  mul_do_addr    out  6   result word read address
//  mul_do         in   64  result word
//  m_valid        out  1   output coef valid
//  m_ready        in   1   output sink ready
//  m_coef         out  2   result coef, same code
//  m_last         out  1   high with coef P-1
//  busy           out  1   high in any state but IDLE
// BEHAVIOUR
//  Reset: state IDLE; all counters, pack regs zero; all outputs 0 except mul_rst=1 while rst=1.
//  FSM: IDLE -> LOAD (immediately after reset release) -> START -> WAIT -> FETCH <-> DRAIN -> CLEAR -> IDLE -> LOAD.
//  IDLE: one cycle, s_ready=0. LOAD: s_ready=1; beat k (0..P-1) placed in lane k%32 of pack_f/pack_g.
//  Word write: cycle after beat with k%32==31 or k==P-1, wr_en_0=wr_en_1=1, addr=k/32, din=pack reg;
//   unfilled lanes (word 23 lanes 25..31) are 2'b00. Pack regs clear on write. Exactly NW writes per port.
//  s_ready drops the cycle after beat P-1 accepted; gaps in s_valid stall packing, no effect on data.
//  START: cycle after word 23 write, mul_in_ready=1 for exactly one cycle.
//  WAIT: until mul_valid=1; no timeout.
//  FETCH: mul_do_addr=w (w=0..NW-1), held RD_LAT cycles, then mul_do latched into out_word.
//  DRAIN: m_valid=1, m_coef=out_word[1:0]; on m_valid&m_ready shift right 2, n++.
//   m_coef/m_last stable while m_ready=0. After 32 coefs (25 for w=NW-1) -> FETCH w+1, or CLEAR after last.
//  m_last=1 only on coef index P-1. Ouput lanes 25..31 of word 23 never emitted.
//  CLEAR: mul_rst=1 for one cycle (multiplier returns to init), then IDLE.
//  mul_rst = rst | (state==CLEAR). mul_do_addr upper bit always 0.
//  Code 2'b11 on input passed through unchecked.
//  rst mid-operation (any state): abort, registers reset, multiplier reset via mul_rst; no partial output
//   after rst; new load starts from beat 0.
//  Latency: start pulse 2 cycles after final input beat; first m_valid RD_LAT+1 cycles after mul_valid.
// TESTING
//  F=1 (coef0=01), G=1 -> port0/1 addr0 din=64'h1, addrs 1..23 din=0; output coef0=01, coefs 1..760=00.
//  F=x^760 (coef760=01), G=x (coef1=01) -> output coef0=01, coef1=01, all others 00 (x^761=x+1).
//  F coef k = code(k%3), G=0 -> addr23 din[63:50]=0; exactly 24 writes each port; output all 00.
//  s_valid random 50% duty, m_ready toggling 1/0 -> 761 coefs in order, no drop/dup, stalled m_coef stable.
//  rst at LOAD beat 100 -> s_ready=0, mul_rst=1 during rst; next full run (F=G=1) gives coef0=01.
//  Two back-to-back runs -> mul_rst pulse between them; second result independent of first.

Source files
------------

// File: rtl/r3_mul_ctrl.sv
// Host-side sequencer for the R3 multiplier: packs two coefficient streams into BRAM words,
// starts the multiplier, unpacks the result words to a coefficient stream, then clears it.
module r3_mul_ctrl #(
  parameter int P      = 761,
  parameter int NW     = 24,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_coef_f,
  input  logic [1:0]  s_coef_g,
  output logic        mul_wr_en_0,
  output logic [4:0]  mul_wr_addr_0,
  output logic [63:0] mul_wr_din_0,
  output logic        mul_wr_en_1,
  output logic [4:0]  mul_wr_addr_1,
  output logic [63:0] mul_wr_din_1,
  output logic        mul_in_ready,
  input  logic        mul_valid,
  output logic        mul_rst,
  output logic [5:0]  mul_do_addr,
  input  logic [63:0] mul_do,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [1:0]  m_coef,
  output logic        m_last,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  // Handshakes: a beat moves on s_valid&s_ready (input) or m_valid&m_ready (output);
  // valid never waits on ready, and a stalled output holds m_coef/m_last unchanged.

  localparam logic [9:0] K_LAST     = 10'(P - 1);
  localparam logic [9:0] K_END      = 10'(P);
  localparam logic [4:0] W_LAST     = 5'(NW - 1);
  localparam logic [4:0] N_FULL     = 5'd31;
  localparam logic [4:0] N_TAIL     = 5'(P - 32 * (NW - 1) - 1);
  localparam logic [3:0] FETCH_LAST = 4'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_FETCH = 3'd4,
    S_DRAIN = 3'd5,
    S_CLEAR = 3'd6
  } state_t;

  state_t      state, state_n;
  logic [9:0]  k;
  logic [63:0] pack_f, pack_g, pack_f_nx, pack_g_nx;
  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [63:0] wr_din_f_q, wr_din_g_q;
  logic [4:0]  w, n;
  logic [3:0]  fcnt;
  logic [63:0] out_word;

  logic       beat, take, word_end, word_last;
  logic [4:0] n_last;

  assign s_ready   = (state == S_LOAD) && (k != K_END) && !rst;
  assign beat      = s_valid && s_ready;
  assign word_end  = (k[4:0] == 5'd31) || (k == K_LAST);
  assign word_last = (w == W_LAST);
  assign n_last    = word_last ? N_TAIL : N_FULL;
  assign m_valid   = (state == S_DRAIN) && !rst;
  assign take      = m_valid && m_ready;

  always_comb begin
    pack_f_nx = pack_f;
    pack_g_nx = pack_g;
    pack_f_nx[{k[4:0], 1'b0} +: 2] = s_coef_f;
    pack_g_nx[{k[4:0], 1'b0} +: 2] = s_coef_g;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_LOAD;
      S_LOAD:  if (wr_en_q && wr_addr_q == W_LAST) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT:  if (mul_valid) state_n = S_FETCH;
      S_FETCH: if (fcnt == FETCH_LAST) state_n = S_DRAIN;
      S_DRAIN: if (take && n == n_last) state_n = word_last ? S_CLEAR : S_FETCH;
      S_CLEAR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      k          <= '0;
      pack_f     <= '0;
      pack_g     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_din_f_q <= '0;
      wr_din_g_q <= '0;
      w          <= '0;
      n          <= '0;
      fcnt       <= '0;
      out_word   <= '0;
    end else begin
      state   <= state_n;
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          k    <= '0;
          w    <= '0;
          n    <= '0;
          fcnt <= '0;
        end
        S_LOAD: begin
          if (beat) begin
            k <= k + 10'd1;
            if (word_end) begin
              // Word completes: hand it to the write port and start the next word empty.
              wr_en_q    <= 1'b1;
              wr_addr_q  <= k[9:5];
              wr_din_f_q <= pack_f_nx;
              wr_din_g_q <= pack_g_nx;
              pack_f     <= '0;
              pack_g     <= '0;
            end else begin
              pack_f <= pack_f_nx;
              pack_g <= pack_g_nx;
            end
          end
        end
        S_FETCH: begin
          if (fcnt == FETCH_LAST) begin
            fcnt     <= '0;
            out_word <= mul_do;
            n        <= '0;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (take) begin
            out_word <= {2'b00, out_word[63:2]};
            if (n == n_last) begin
              n <= '0;
              w <= w + 5'd1;
            end else begin
              n <= n + 5'd1;
            end
          end
        end
        S_CLEAR: begin
          k <= '0;
          w <= '0;
        end
        default: ;
      endcase
    end
  end

  // While draining, the read address already points at the next word so it is
  // valid by the time FETCH latches it.
  assign mul_do_addr   = {1'b0, (state == S_DRAIN) ? w + 5'd1 : w};
  assign mul_wr_en_0   = wr_en_q && !rst;
  assign mul_wr_en_1   = wr_en_q && !rst;
  assign mul_wr_addr_0 = wr_addr_q;
  assign mul_wr_addr_1 = wr_addr_q;
  assign mul_wr_din_0  = wr_din_f_q;
  assign mul_wr_din_1  = wr_din_g_q;
  assign mul_in_ready  = (state == S_START) && !rst;
  assign mul_rst       = rst || (state == S_CLEAR);
  assign m_coef        = m_valid ? out_word[1:0] : 2'b00;
  assign m_last        = m_valid && word_last && (n == N_TAIL);
  assign busy          = (state != S_IDLE) && !rst;
  assign dbg_state     = state;

endmodule
